sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives both ports of the dual-port sram block: write enable/pointer on one side, read enable/pointer on the other.
- Users see push/pop, status flags, occupancy count, a read-data-valid strobe and sticky error flags.
- Sits between the producer/consumer logic and the sram; the sram's wrclk and rdclk are both tied to this block's clk.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_fifo_ctrl_if.sv | 42 ++++
 rtl/fifo_ptr_wrap.sv | 28 ++
 rtl/sync_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller.
//   FIFO_PTR_DEF / FIFO_DEPTH_DEF : default pointer width and entry count
//   depth_ok()                    : legal-configuration check for a depth/pointer pair
//   count_w()                     : occupancy counter width for a pointer width
package fifo_pkg;

  localparam int FIFO_PTR_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 16;

  // The depth must be at least 2 and must fit in the pointer range.
  function automatic bit depth_ok(input int ptr_w, input int depth);
    return (depth >= 2) && (depth <= (1 << ptr_w));
  endfunction

  // One extra bit so that a completely full FIFO is representable.
  function automatic int count_w(input int ptr_w);
    return ptr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Bundle of user-side and sram-side signals of the FIFO controller.
//   master : producer/consumer/sram side (drives push, pop, clr_err)
//   slave  : the controller (drives sram enables/pointers, status, errors)
interface sync_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int FIFO_PTR = FIFO_PTR_DEF
);

  localparam int CW = count_w(FIFO_PTR);

  logic                push;
  logic                pop;
  logic                clr_err;
  logic                wren;
  logic [FIFO_PTR-1:0] wrptr;
  logic                rden;
  logic [FIFO_PTR-1:0] rdptr;
  logic                rd_valid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [CW-1:0]       count;
  logic                overflow;
  logic                underflow;

  modport master (
    output push, pop, clr_err,
    input  wren, wrptr, rden, rdptr, rd_valid,
    input  full, empty, almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err,
    output wren, wrptr, rden, rdptr, rd_valid,
    output full, empty, almost_full, almost_empty, count,
    output overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr_wrap.sv
// Wrapping pointer for the FIFO controller.
//   clk, rst : clock and asynchronous active-high reset
//   en       : advance the pointer by one this cycle
//   ptr      : current pointer, wraps from FIFO_DEPTH-1 back to 0
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int FIFO_PTR   = FIFO_PTR_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [FIFO_PTR-1:0] ptr
);

  // Explicit compare keeps non-power-of-two depths correct.
  localparam logic [FIFO_PTR-1:0] LAST = FIFO_PTR'(FIFO_DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving both ports of a dual-port sram.
//   clk, rst : clock (shared with sram) and asynchronous active-high reset
//   bus      : slave side of sync_fifo_ctrl_if
//              in : push, pop, clr_err
//              out: wren/wrptr, rden/rdptr to the sram, rd_valid,
//                   full, empty, almost_full, almost_empty, count,
//                   sticky overflow/underflow
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_PTR   = FIFO_PTR_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_ctrl_if.slave  bus
);

  localparam int            CW      = count_w(FIFO_PTR);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!depth_ok(FIFO_PTR, FIFO_DEPTH)) begin : g_cfg_err
    $error("sync_fifo_ctrl: FIFO_DEPTH must lie in [2, 2**FIFO_PTR]");
  end

  logic                push_ok;
  logic                pop_ok;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_next;
  logic                full_q;
  logic                empty_q;
  logic                af_q;
  logic                ae_q;
  logic                rd_valid_p1;
  logic                overflow_q;
  logic                underflow_q;
  logic [FIFO_PTR-1:0] wrptr;
  logic [FIFO_PTR-1:0] rdptr;

  // Acceptance uses the registered flags. A push at full is refused even
  // with a pop, and a pop at empty is refused even with a push, so the sram
  // never reads and writes the same address in one cycle. The rst term keeps
  // the sram enables low while reset is held.
  assign push_ok = bus.push & ~full_q  & ~rst;
  assign pop_ok  = bus.pop  & ~empty_q & ~rst;

  always_comb begin
    count_next = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  fifo_ptr_wrap #(.FIFO_PTR(FIFO_PTR), .FIFO_DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (push_ok),
    .ptr (wrptr)
  );

  fifo_ptr_wrap #(.FIFO_PTR(FIFO_PTR), .FIFO_DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (pop_ok),
    .ptr (rdptr)
  );

  // Flags come from count_next so they line up with count without lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= AF_C);
      ae_q    <= (count_next <= AE_C);
    end
  end

  // Read-data strobe: sram rddata is valid one cycle after rden.
  // Error flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_p1 <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_p1 <= pop_ok;
      overflow_q  <= (bus.push & full_q)  | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.pop  & empty_q) | (underflow_q & ~bus.clr_err);
    end
  end

  assign bus.wren         = push_ok;
  assign bus.rden         = pop_ok;
  assign bus.wrptr        = wrptr;
  assign bus.rdptr        = rdptr;
  assign bus.rd_valid     = rd_valid_p1;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a depth-16 instance with a behavioural sram
// and read-data scoreboard, plus a depth-10 instance for wrap and
// asynchronous-reset checks.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst10 = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sync_fifo_ctrl_if #(.FIFO_PTR(4)) bus ();
  sync_fifo_ctrl_if #(.FIFO_PTR(4)) bus10 ();

  sync_fifo_ctrl #(.FIFO_PTR(4), .FIFO_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sync_fifo_ctrl #(.FIFO_PTR(4), .FIFO_DEPTH(10), .AF_LEVEL(8), .AE_LEVEL(2)) u_dut10 (
    .clk (clk),
    .rst (rst10),
    .bus (bus10)
  );

  // Behavioural dual-port sram on the depth-16 instance.
  logic [7:0] wdata = 8'h00;
  logic [7:0] rddata;
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.wren) mem[bus.wrptr] <= wdata;
    if (bus.rden) rddata <= mem[bus.rdptr];
  end

  // Expected read data in push order.
  logic [7:0] sb[$];

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_data_unexpected: got %0d with no data expected", rddata);
      end else begin
        logic [7:0] exp_d;
        exp_d = sb.pop_front();
        if (rddata !== exp_d) begin
          errors++;
          $display("FAIL rd_data: got %0d expected %0d", rddata, exp_d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a push with data; queue it if it is expected to be accepted.
  task automatic set_push(input logic p, input logic [7:0] d, input bit accepted);
    bus.push = p;
    wdata    = d;
    if (p && accepted) sb.push_back(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] diff;
    bus.push = 0; bus.pop = 0; bus.clr_err = 0;
    bus10.push = 0; bus10.pop = 0; bus10.clr_err = 0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    rst = 0; rst10 = 0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_empty", bus.empty, 1);
    check("rst_almost_empty", bus.almost_empty, 1);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 0);
    check("rst_almost_full", bus.almost_full, 0);
    check("rst_wren", bus.wren, 0);
    check("rst_rden", bus.rden, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    tick();

    // 16 pushes fill the FIFO.
    for (int i = 0; i < 16; i++) begin
      set_push(1, 8'(i * 17 + 3), 1);
      @(negedge clk);
      check("fill_wren", bus.wren, 1);
      check("fill_wrptr", bus.wrptr, i);
      tick();
      check("fill_count", bus.count, i + 1);
      check("fill_almost_full", bus.almost_full, (i + 1 >= 12) ? 1 : 0);
    end
    check("fill_wrptr_wrap", bus.wrptr, 0);
    check("fill_full", bus.full, 1);
    // 17th push is refused and flagged.
    set_push(1, 8'hAA, 0);
    @(negedge clk);
    check("ovf_wren", bus.wren, 0);
    tick();
    check("ovf_overflow", bus.overflow, 1);
    check("ovf_count", bus.count, 16);
    set_push(0, 8'h00, 0);

    // 16 pops drain it; data is checked by the scoreboard.
    bus.pop = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("drain_rden", bus.rden, 1);
      check("drain_rdptr", bus.rdptr, i);
      tick();
      check("drain_count", bus.count, 15 - i);
    end
    check("drain_empty", bus.empty, 1);
    @(negedge clk);
    check("udf_rden", bus.rden, 0);
    tick();
    check("udf_underflow", bus.underflow, 1);
    check("udf_rd_valid", bus.rd_valid, 0);
    // clr_err together with a fresh underflow: underflow stays, overflow clears.
    bus.clr_err = 1;
    tick();
    check("clr_set_wins_udf", bus.underflow, 1);
    check("clr_overflow", bus.overflow, 0);
    bus.pop = 0;
    tick();
    check("clr_underflow", bus.underflow, 0);
    bus.clr_err = 0;

    // Steady state at count 5 with simultaneous push and pop.
    for (int i = 0; i < 5; i++) begin
      set_push(1, 8'(100 + i), 1);
      tick();
    end
    check("steady_fill_count", bus.count, 5);
    bus.pop = 1;
    for (int j = 0; j < 20; j++) begin
      set_push(1, 8'(200 + j), 1);
      tick();
      diff = bus.wrptr - bus.rdptr;
      check("steady_count", bus.count, 5);
      check("steady_ptr_gap", diff, 5);
    end
    check("steady_wrptr", bus.wrptr, 9);
    check("steady_rdptr", bus.rdptr, 4);
    bus.pop = 0;
    for (int i = 0; i < 11; i++) begin
      set_push(1, 8'(50 + i), 1);
      tick();
    end
    check("refill_full", bus.full, 1);

    // Full with push and pop: only the pop is accepted.
    set_push(1, 8'hEE, 0);
    bus.pop = 1;
    @(negedge clk);
    check("full_both_wren", bus.wren, 0);
    check("full_both_rden", bus.rden, 1);
    tick();
    check("full_both_count", bus.count, 15);
    check("full_both_full", bus.full, 0);
    check("full_both_overflow", bus.overflow, 1);
    set_push(0, 8'h00, 0);
    repeat (15) tick();
    check("redrain_empty", bus.empty, 1);

    // Empty with push and pop: only the push is accepted.
    set_push(1, 8'h77, 1);
    @(negedge clk);
    check("empty_both_wren", bus.wren, 1);
    check("empty_both_rden", bus.rden, 0);
    tick();
    check("empty_both_count", bus.count, 1);
    check("empty_both_underflow", bus.underflow, 1);
    check("empty_both_rd_valid", bus.rd_valid, 0);
    set_push(0, 8'h00, 0);
    tick();
    bus.pop = 0;
    repeat (2) tick();
    check("final_count", bus.count, 0);
    check("sb_drained", sb.size(), 0);

    // Depth-10 instance: wrap at 9 and full at 10.
    for (int i = 0; i < 10; i++) begin
      bus10.push = 1;
      @(negedge clk);
      check("d10_wrptr", bus10.wrptr, i);
      tick();
    end
    bus10.push = 0;
    check("d10_wrptr_wrap", bus10.wrptr, 0);
    check("d10_full", bus10.full, 1);
    check("d10_count", bus10.count, 10);
    check("d10_almost_full", bus10.almost_full, 1);
    bus10.pop = 1;
    repeat (3) tick();
    check("d10_rd_valid_pending", bus10.rd_valid, 1);

    // Reset mid-burst, checked before any clock edge.
    bus10.push = 1;
    rst10 = 1;
    #1;
    check("d10_arst_count", bus10.count, 0);
    check("d10_arst_wrptr", bus10.wrptr, 0);
    check("d10_arst_rdptr", bus10.rdptr, 0);
    check("d10_arst_empty", bus10.empty, 1);
    check("d10_arst_almost_empty", bus10.almost_empty, 1);
    check("d10_arst_full", bus10.full, 0);
    check("d10_arst_almost_full", bus10.almost_full, 0);
    check("d10_arst_wren", bus10.wren, 0);
    check("d10_arst_rden", bus10.rden, 0);
    check("d10_arst_rd_valid", bus10.rd_valid, 0);
    tick();
    bus10.push = 0; bus10.pop = 0;
    rst10 = 0;
    tick();
    check("d10_post_rst_count", bus10.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
